// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader.
// Holds the 3-bit loader state encoding and the image header geometry.
// The length header and each data word are both big-endian byte pairs, so
// the byte-pair assembler sizes its hi/lo phase index from the header size.
package boot_loader_pkg;

  localparam int IMAGE_HDR_BYTES = 2;
  localparam int PAIR_IDX_W      = $clog2(IMAGE_HDR_BYTES);

  // LEN and DATA each cover a hi and a lo byte.
  // The assembler tracks which byte of the pair is expected next.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/boot_loader_byte_pair_assembler.sv
// Big-endian byte pair assembler.
// The first accepted byte is held as the high byte.  When the second byte is
// accepted, word_vld_o pulses in that same cycle with word_o = {hi, lo}.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   clr_i       synchronous restart to the high-byte phase
//   byte_vld_i  a byte is accepted this cycle
//   byte_i      accepted byte
//   word_o      assembled word, valid when word_vld_o
//   word_vld_o  low byte accepted this cycle, word complete
module boot_loader_byte_pair_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o,
  output logic        word_vld_o
);

  logic [PAIR_IDX_W-1:0] phase_q;
  logic [7:0]            hi_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      phase_q <= '0;
      hi_q    <= 8'h00;
    end else if (byte_vld_i) begin
      if (phase_q == '0) begin
        hi_q    <= byte_i;
        phase_q <= '1;
      end else begin
        phase_q <= '0;
      end
    end
  end

  assign word_vld_o = byte_vld_i && (phase_q != '0);
  assign word_o     = {hi_q, byte_i};

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a program image from a byte-serial source into main
// memory and then releases the CPU reset.
// Image layout: 16-bit big-endian word count N, followed by N big-endian words.
// Ports:
//   CLK      system clock, rising edge
//   CtrlRst  synchronous active-high reset, aborts any load in progress
//   RxValid  RxByte valid
//   RxByte   image byte
//   RxReady  byte accepted when RxValid & RxReady
//   LdWrite  one-cycle memory write strobe
//   LdAddr   memory word address (BASE_ADDR + words written so far)
//   LdData   memory word data
//   CpuRst   CPU reset, high until the image is loaded
//   Done     sticky, image loaded and CPU released
//   Error    sticky, word count exceeded MAX_WORDS
//
// state   | meaning
// IDLE    | first cycle after reset, not yet accepting bytes
// LEN     | accepting the two word-count bytes
// DATA    | accepting the two bytes of the next word
// WRITE   | one-cycle memory write of the assembled word
// HOLD    | RELEASE_DELAY cycles before the CPU is released
// RUN     | CPU released, loader idle until reset
// ERR     | bad word count, CPU held in reset until reset
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int          MAX_WORDS     = 1024,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic        CLK,
  input  logic        CtrlRst,
  input  logic        RxValid,
  input  logic [7:0]  RxByte,
  output logic        RxReady,
  output logic        LdWrite,
  output logic [15:0] LdAddr,
  output logic [15:0] LdData,
  output logic        CpuRst,
  output logic        Done,
  output logic        Error
);

  localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);
  // HOLD is occupied while the timer runs from RELEASE_DELAY-1 down to 0,
  // so exactly RELEASE_DELAY cycles separate the last write from CpuRst low.
  localparam logic [3:0]  DLY_LOAD = 4'(RELEASE_DELAY - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dly_q, dly_d;

  logic        byte_acc;
  logic [15:0] asm_word;
  logic        asm_vld;
  logic [15:0] cnt_inc;

  assign byte_acc = RxValid && RxReady;
  assign cnt_inc  = cnt_q + 16'd1;

  boot_loader_byte_pair_assembler u_asm (
    .clk_i      (CLK),
    .rst_i      (CtrlRst),
    .clr_i      (state_q == S_IDLE),
    .byte_vld_i (byte_acc),
    .byte_i     (RxByte),
    .word_o     (asm_word),
    .word_vld_o (asm_vld)
  );

  always_ff @(posedge CLK) begin
    if (CtrlRst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      len_q   <= 16'd0;
      data_q  <= 16'd0;
      dly_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    dly_d   = dly_q;
    case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN: begin
        if (asm_vld) begin
          len_d = asm_word;
          if (asm_word == 16'd0) begin
            state_d = S_HOLD;
            dly_d   = DLY_LOAD;
          end else if ({1'b0, asm_word} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (asm_vld) begin
          data_d  = asm_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
          state_d = S_HOLD;
          dly_d   = DLY_LOAD;
        end else begin
          state_d = S_DATA;
        end
      end
      S_HOLD: begin
        if (dly_q == 4'd0) state_d = S_RUN;
        else               dly_d   = dly_q - 4'd1;
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // The loader owns the memory port for as long as the CPU is in reset; once
  // released the strobe can no longer assert, so the port is free for the CPU.
  assign CpuRst  = (state_q != S_RUN);
  assign RxReady = (state_q == S_LEN) || (state_q == S_DATA);
  assign LdWrite = (state_q == S_WRITE) && CpuRst;
  assign LdAddr  = BASE_ADDR + cnt_q;
  assign LdData  = data_q;
  assign Done    = (state_q == S_RUN);
  assign Error   = (state_q == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 1024;
  localparam int          DLY  = 4;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    logic [63:0] img;
    int          nbytes;
    int          gap;
    int          exp_nwr;
    bit          exp_err;
    logic [15:0] exp_last;
  } vec_t;

  logic        CLK;
  logic        CtrlRst;
  logic        RxValid;
  logic [7:0]  RxByte;
  logic        RxReady;
  logic        LdWrite;
  logic [15:0] LdAddr;
  logic [15:0] LdData;
  logic        CpuRst;
  logic        Done;
  logic        Error;

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .RELEASE_DELAY(DLY)) dut (
    .CLK     (CLK),
    .CtrlRst (CtrlRst),
    .RxValid (RxValid),
    .RxByte  (RxByte),
    .RxReady (RxReady),
    .LdWrite (LdWrite),
    .LdAddr  (LdAddr),
    .LdData  (LdData),
    .CpuRst  (CpuRst),
    .Done    (Done),
    .Error   (Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int test_id  = 0;

  // monitor state, owned by the monitor process only
  int          mon_id   = 0;
  int          acc_cnt  = 0;
  int          last_evt = -1;
  int          rel_cyc  = -1;
  int          lat_err  = 0;
  bit          prev_acc = 1'b0;
  logic [31:0] wr_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (test_id != mon_id) begin
      mon_id   = test_id;
      wr_q.delete();
      acc_cnt  = 0;
      last_evt = -1;
      rel_cyc  = -1;
      lat_err  = 0;
      prev_acc = 1'b0;
    end
    if (!CtrlRst) begin
      if (LdWrite) begin
        wr_q.push_back({LdAddr, LdData});
        last_evt = cyc;
        // a write must directly follow acceptance of a data word's low byte
        if (!(prev_acc && acc_cnt >= 4 && (acc_cnt % 2) == 0)) lat_err++;
      end
      prev_acc = RxValid && RxReady;
      if (prev_acc) begin
        acc_cnt++;
        if (acc_cnt == 2) last_evt = cyc;
      end
      if (!CpuRst && rel_cyc < 0) rel_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset();
    test_id++;
    CtrlRst = 1'b1;
    RxValid = 1'b0;
    RxByte  = 8'h00;
    @(posedge CLK); #1;
    chk("rst_rxready", RxReady, 0);
    chk("rst_ldwrite", LdWrite, 0);
    chk("rst_ldaddr",  LdAddr,  BASE);
    chk("rst_lddata",  LdData,  0);
    chk("rst_cpurst",  CpuRst,  1);
    chk("rst_done",    Done,    0);
    chk("rst_error",   Error,   0);
    CtrlRst = 1'b0;
  endtask

  task automatic send_bytes(input byte_q_t q, input int gap);
    bit acc;
    int guard;
    foreach (q[i]) begin
      guard = 0;
      while ($urandom_range(0, 99) < gap && guard < 20) begin
        RxValid = 1'b0;
        RxByte  = 8'($urandom);
        @(posedge CLK); #1;
        guard++;
      end
      RxValid = 1'b1;
      RxByte  = q[i];
      acc     = 1'b0;
      guard   = 0;
      while (!acc && guard < 100) begin
        @(negedge CLK);
        acc = RxReady;
        @(posedge CLK); #1;
        guard++;
      end
      RxValid = 1'b0;
      if (!acc) begin
        chk("rx_accept_timeout", acc, 1);
        return;
      end
    end
  endtask

  // Reference: the image header decides error vs. load; word i goes to BASE+i.
  task automatic check_outcome(input byte_q_t img);
    int          n;
    int          exp_n;
    bit          err;
    int          guard;
    logic [15:0] exp_d;
    n     = {img[0], img[1]};
    err   = (n > MAXW);
    exp_n = err ? 0 : n;
    guard = 0;
    while (!(Done || Error) && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    chk("done_or_error_seen", Done | Error, 1);
    repeat (3) @(negedge CLK);
    chk("num_writes", wr_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_q.size(); i++) begin
      exp_d = {img[2 + 2*i], img[3 + 2*i]};
      chk("wr_addr", wr_q[i][31:16], 16'(BASE + 16'(i)));
      chk("wr_data", wr_q[i][15:0], exp_d);
    end
    chk("done",    Done,    !err);
    chk("error",   Error,   err);
    chk("cpurst",  CpuRst,  err);
    chk("rxready_after", RxReady, 0);
    chk("done_error_excl", Done & Error, 0);
    chk("write_latency", lat_err, 0);
    if (!err) chk("release_delay", rel_cyc - last_evt, DLY + 1);
    @(posedge CLK); #1;
  endtask

  vec_t    tbl [6];
  byte_q_t q;
  int      n0;
  int      nw;

  initial begin
    CtrlRst = 1'b1;
    RxValid = 1'b0;
    RxByte  = 8'h00;

    tbl[0] = '{64'h0002_1234_ABCD_0000, 6, 0,  2, 1'b0, 16'hABCD};
    tbl[1] = '{64'h0000_0000_0000_0000, 2, 0,  0, 1'b0, 16'h0000};
    tbl[2] = '{64'h0401_0000_0000_0000, 2, 0,  0, 1'b1, 16'h0000};
    tbl[3] = '{64'h0003_DEAD_BEEF_0102, 8, 50, 3, 1'b0, 16'h0102};
    tbl[4] = '{64'h0001_5AA5_0000_0000, 4, 0,  1, 1'b0, 16'h5AA5};
    tbl[5] = '{64'h0002_FFFF_0000_0000, 6, 30, 2, 1'b0, 16'h0000};

    @(posedge CLK); #1;

    foreach (tbl[t]) begin
      do_reset();
      q.delete();
      for (int i = 0; i < tbl[t].nbytes; i++) q.push_back(tbl[t].img[63 - 8*i -: 8]);
      send_bytes(q, tbl[t].gap);
      check_outcome(q);
      chk("tbl_nwr", wr_q.size(), tbl[t].exp_nwr);
      if (wr_q.size() > 0) chk("tbl_last_data", wr_q[$][15:0], tbl[t].exp_last);
    end

    // Reset after three data bytes, then a fresh one-word image.
    do_reset();
    q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_bytes(q, 0);
    do_reset();
    q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    send_bytes(q, 0);
    check_outcome(q);

    // Bytes after Done are ignored.
    n0 = wr_q.size();
    for (int i = 0; i < 10; i++) begin
      RxValid = 1'b1;
      RxByte  = 8'($urandom);
      @(posedge CLK); #1;
    end
    RxValid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("extra_nwr",     wr_q.size(), n0);
    chk("extra_cpurst",  CpuRst,  0);
    chk("extra_done",    Done,    1);
    chk("extra_rxready", RxReady, 0);
    @(posedge CLK); #1;

    // Largest legal image.
    do_reset();
    q = '{8'h04, 8'h00};
    for (int i = 0; i < 2*MAXW; i++) q.push_back(8'($urandom));
    send_bytes(q, 10);
    check_outcome(q);

    // Random images with random valid gaps; the last trial has an oversize header.
    for (int r = 0; r < 6; r++) begin
      nw = (r == 5) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(1, 8));
      q.delete();
      q.push_back(8'(nw >> 8));
      q.push_back(8'(nw));
      if (nw <= MAXW) for (int i = 0; i < 2*nw; i++) q.push_back(8'($urandom));
      do_reset();
      send_bytes(q, int'($urandom_range(0, 70)));
      check_outcome(q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
